// File: rtl/crossword_pkg.sv
// Shared constants and types for the crossword cursor/entry sequencer.
package crossword_pkg;

  localparam int GRID_W_DEF  = 5;
  localparam int GRID_H_DEF  = 5;
  localparam int CELL_PX_DEF = 80;

  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_DOWN  = 8'h51;
  localparam logic [7:0] KEY_UP    = 8'h52;
  localparam logic [7:0] KEY_BKSP  = 8'h2A;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_Z     = 8'h1D;

  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_SEEK, ST_WRITE} cursor_state_t;
  typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP} dir_t;

  function automatic logic is_arrow(input logic [7:0] k);
    return (k >= KEY_RIGHT) && (k <= KEY_UP);
  endfunction

  function automatic logic is_letter(input logic [7:0] k);
    return (k >= KEY_A) && (k <= KEY_Z);
  endfunction

  function automatic dir_t key_dir(input logic [7:0] k);
    case (k)
      KEY_LEFT: return DIR_LEFT;
      KEY_DOWN: return DIR_DOWN;
      KEY_UP:   return DIR_UP;
      default:  return DIR_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/cursor_ctrl_key_event.sv
// Keycode edge detector: press pulses on any new nonzero code, repeat pulses
// while an enabled key stays held.
module cursor_ctrl_key_event
  import crossword_pkg::*;
#(
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       rpt_en,
  output logic       press,
  output logic       rpt,
  output logic [7:0] key_held
);

  localparam int CW = $clog2(REPEAT_DELAY + 1);

  logic [7:0]    key_prev;
  logic [CW-1:0] rpt_cnt;
  logic          same_key;

  assign same_key = (keycode != 8'h00) && (keycode == key_prev);
  assign press    = (keycode != 8'h00) && (keycode != key_prev);
  assign rpt      = same_key && rpt_en && (rpt_cnt == CW'(REPEAT_DELAY));
  assign key_held = key_prev;

  // The counter freezes (rather than clears) while repeat is disabled, so a
  // seek in progress does not restart the repeat cadence.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      key_prev <= 8'h00;
      rpt_cnt  <= '0;
    end else begin
      key_prev <= keycode;
      if (!same_key)
        rpt_cnt <= '0;
      else if (rpt_en)
        rpt_cnt <= (rpt_cnt == CW'(REPEAT_DELAY)) ? CW'(REPEAT_DELAY - REPEAT_RATE)
                                                  : rpt_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cursor_ctrl.sv
// Crossword cursor sequencer: arrow moves with black-cell skipping, letter and
// erase writes over valid/ready, auto-advance, and VGA highlight coordinates.
module cursor_ctrl
  import crossword_pkg::*;
#(
  parameter int GRID_W       = GRID_W_DEF,
  parameter int GRID_H       = GRID_H_DEF,
  parameter int CELL_PX      = CELL_PX_DEF,
  parameter int X_ORIGIN     = 3,
  parameter int Y_ORIGIN     = 80,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic [7:0]               keycode,
  input  logic [GRID_W*GRID_H-1:0] black_mask,
  input  logic                     wr_ready,
  output logic                     wr_valid,
  output logic [4:0]               wr_addr,
  output logic [7:0]               wr_char,
  output logic                     dir_down,
  output logic [2:0]               cur_row,
  output logic [2:0]               cur_col,
  output logic [9:0]               highlightX,
  output logic [9:0]               highlightY
);

  function automatic logic at_edge(input dir_t d, input logic [2:0] r, input logic [2:0] c);
    case (d)
      DIR_RIGHT: return c == 3'(GRID_W - 1);
      DIR_LEFT:  return c == 3'd0;
      DIR_DOWN:  return r == 3'(GRID_H - 1);
      default:   return r == 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] step_row(input dir_t d, input logic [2:0] r);
    case (d)
      DIR_DOWN: return r + 3'd1;
      DIR_UP:   return r - 3'd1;
      default:  return r;
    endcase
  endfunction

  function automatic logic [2:0] step_col(input dir_t d, input logic [2:0] c);
    case (d)
      DIR_RIGHT: return c + 3'd1;
      DIR_LEFT:  return c - 3'd1;
      default:   return c;
    endcase
  endfunction

  function automatic logic [4:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
    return 5'(int'(r) * GRID_W + int'(c));
  endfunction

  function automatic logic [9:0] pix(input int origin, input logic [2:0] i);
    return 10'(origin) + 10'(i) * 10'(CELL_PX);
  endfunction

  cursor_state_t state;
  cursor_state_t exit_state;
  dir_t          seek_dir;
  dir_t          ev_dir;
  dir_t          wr_dir;
  logic [2:0]    cand_row;
  logic [2:0]    cand_col;
  logic [4:0]    cur_idx;
  logic [4:0]    cand_idx;
  logic          press;
  logic          rpt;
  logic          rpt_en;
  logic          ev_valid;
  logic [7:0]    key_held;
  logic [7:0]    ev_key;

  assign rpt_en = (state == ST_HELD) && is_arrow(keycode);

  cursor_ctrl_key_event #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_key_event (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .keycode  (keycode),
    .rpt_en   (rpt_en),
    .press    (press),
    .rpt      (rpt),
    .key_held (key_held)
  );

  assign ev_valid   = press || rpt;
  assign ev_key     = press ? keycode : key_held;
  assign ev_dir     = key_dir(ev_key);
  assign cur_idx    = cell_idx(cur_row, cur_col);
  assign cand_idx   = cell_idx(cand_row, cand_col);
  assign exit_state = (keycode != 8'h00) ? ST_HELD : ST_IDLE;

  // Letters advance along the entry direction; erase backs up against it.
  always_comb begin
    wr_dir = DIR_RIGHT;
    if (wr_char != 8'h00) wr_dir = dir_down ? DIR_DOWN : DIR_RIGHT;
    else                  wr_dir = dir_down ? DIR_UP   : DIR_LEFT;
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      seek_dir   <= DIR_RIGHT;
      cand_row   <= 3'd0;
      cand_col   <= 3'd0;
      cur_row    <= 3'd0;
      cur_col    <= 3'd0;
      highlightX <= 10'(X_ORIGIN);
      highlightY <= 10'(Y_ORIGIN);
      dir_down   <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= 5'd0;
      wr_char    <= 8'h00;
    end else begin
      case (state)
        ST_IDLE, ST_HELD: begin
          state <= exit_state;
          if (ev_valid) begin
            if (is_arrow(ev_key)) begin
              if (!at_edge(ev_dir, cur_row, cur_col)) begin
                seek_dir <= ev_dir;
                cand_row <= step_row(ev_dir, cur_row);
                cand_col <= step_col(ev_dir, cur_col);
                state    <= ST_SEEK;
              end
            end else if (ev_key == KEY_SPACE) begin
              dir_down <= ~dir_down;
            end else if (is_letter(ev_key) || ev_key == KEY_BKSP) begin
              if (!black_mask[cur_idx]) begin
                wr_valid <= 1'b1;
                wr_addr  <= cur_idx;
                wr_char  <= is_letter(ev_key) ? ev_key : 8'h00;
                state    <= ST_WRITE;
              end
            end
          end
        end
        ST_SEEK: begin
          if (!black_mask[cand_idx]) begin
            cur_row    <= cand_row;
            cur_col    <= cand_col;
            highlightX <= pix(X_ORIGIN, cand_col);
            highlightY <= pix(Y_ORIGIN, cand_row);
            state      <= exit_state;
          end else if (at_edge(seek_dir, cand_row, cand_col)) begin
            state <= exit_state;
          end else begin
            cand_row <= step_row(seek_dir, cand_row);
            cand_col <= step_col(seek_dir, cand_col);
          end
        end
        ST_WRITE: begin
          if (wr_ready) begin
            wr_valid <= 1'b0;
            if (at_edge(wr_dir, cur_row, cur_col)) begin
              state <= exit_state;
            end else begin
              seek_dir <= wr_dir;
              cand_row <= step_row(wr_dir, cur_row);
              cand_col <= step_col(wr_dir, cur_col);
              state    <= ST_SEEK;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cursor_ctrl.md
Name: cursor_ctrl

Overview:
Keyboard-driven cursor and entry sequencer for the 5x5 crossword grid.
- Turns raw keycodes (sampled once per frame_clk) into discrete press and auto-repeat events.
- Moves the highlight cursor cell-by-cell, skipping black cells.
- Issues letter and erase writes to the grid-store over a valid/ready handshake, then auto-advances in the current entry direction.
- Drives highlightX/highlightY for the VGA overlay.

Parameters:
GRID_W, 5, columns
GRID_H, 5, rows
CELL_PX, 80, cell pitch in pixels
X_ORIGIN, 3, pixel X of column 0
Y_ORIGIN, 80, pixel Y of row 0
REPEAT_DELAY, 20, cycles an arrow key must be held before the first repeat
REPEAT_RATE, 6, cycles between subsequent repeats

Ports:
frame_clk  in  1  sole clock
Reset  in  1  synchronous, active-high
keycode  in  8  USB HID keycode, 0 = no key
black_mask  in  GRID_W*GRID_H  bit r*GRID_W+c set = black cell
wr_ready  in  1  grid-store accepts write
wr_valid  out  1  write request
wr_addr  out  5  r*GRID_W+c
wr_char  out  8  HID letter code; 0x00 = erase
dir_down  out  1  entry direction, 0 = across, 1 = down
cur_row  out  3  cursor row
cur_col  out  3  cursor column
highlightX  out  10  X_ORIGIN + cur_col*CELL_PX
highlightY  out  10  Y_ORIGIN + cur_row*CELL_PX

Behaviour:
- One clock domain, frame_clk. Reset is synchronous and active-high.
- Reset values: cur_row=0, cur_col=0, highlightX=X_ORIGIN, highlightY=Y_ORIGIN, dir_down=0, wr_valid=0, wr_addr=0, wr_char=0, FSM=IDLE, key_prev=0, repeat counter=0.
- Key decode:
  - 0x4F right, 0x50 left, 0x51 down, 0x52 up.
  - 0x04-0x1D letter, 0x2A backspace, 0x2C space.
  - Any other code is ignored, but it is still tracked in key_prev.
- Press event: keycode!=0 and keycode!=key_prev. key_prev<=keycode every cycle in every state.
  - A change from one nonzero key to another nonzero key is a new press.
- Repeat event: arrows only, while the same key is held in HELD.
  - Counter increments each cycle; fires at count==REPEAT_DELAY.
  - After firing, counter reloads to REPEAT_DELAY-REPEAT_RATE.
  - Counter clears on key change or release.
- FSM states: IDLE, HELD, SEEK, WRITE.
  - IDLE/HELD, arrow event: if cursor is at the grid edge in that direction, no change. Otherwise cand<=cursor+delta -> SEEK.
  - IDLE/HELD, letter event: if current cell is black, ignore. Otherwise wr_valid<=1, wr_addr<=current, wr_char<=keycode -> WRITE.
  - IDLE/HELD, backspace event: same as letter but wr_char<=0x00.
  - IDLE/HELD, space event: toggle dir_down next edge. No write, no move.
  - SEEK, each cycle:
    - cand non-black: commit cursor=cand and update highlightX/Y on the same edge -> exit.
    - cand black and at the edge: abandon, cursor unchanged -> exit.
    - Otherwise step cand by delta.
  - WRITE: wr_valid and wr_addr/wr_char are held stable until the cycle where wr_valid&&wr_ready.
    - On that edge: wr_valid<=0.
    - Letter: SEEK in the entry direction (right if dir_down=0, down if 1).
    - Backspace: SEEK in the reverse entry direction.
    - If already at the edge for that SEEK: exit instead.
  - Exit from SEEK/WRITE: HELD if keycode!=0, else IDLE.
- Latency:
  - Unblocked arrow press sampled at edge N: cursor updated at edge N+1.
  - Each black cell skipped adds 1 cycle.
  - Write request is visible the cycle after the press edge.
- Events arriving in SEEK or WRITE are dropped, not queued.
- No wrap-around at any edge.
- Reset in any state: a synchronous return to reset values, including wr_valid=0 even mid-handshake.
- highlightX/Y are registered and always consistent with cur_row/cur_col.
- Width rules: multiply with 10-bit results; products must not exceed 10 bits with the given parameters.

Decomposition:
- crossword_pkg:
  - keycode constants (KEY_RIGHT/LEFT/DOWN/UP, KEY_BKSP, KEY_SPACE, KEY_A, KEY_Z).
  - GRID_W/GRID_H/CELL_PX defaults.
  - cursor FSM state enum.
- One sub-module, key_event: key_prev register, press detect, repeat counter. Outputs press and repeat pulses plus the held keycode.

Test Plan:
- Reset held 2 cycles -> highlightX=3, highlightY=80, cur_row=cur_col=0, wr_valid=0.
- keycode=0x4F for 1 cycle then 0 -> next edge cur_col=1, highlightX=83. Then hold 0x4F 100 cycles (DELAY=20, RATE=6) -> repeats move cur_col to 4, highlightX=323, then no further change (no wrap).
- Black cells:
  - black_mask bit1 set, cursor (0,0), press 0x4F -> cursor (0,2) after 2 cycles.
  - Bits 1-4 set -> cursor stays (0,0).
- Letter write with stall:
  - Press 0x04 at (0,0), wr_ready low 3 cycles -> wr_valid=1, addr=0, char=0x04 stable throughout. Ready high -> cursor (0,1).
  - Then space, then 0x05 -> write addr 1, cursor (1,1).
- In down mode at (1,1), press 0x2A -> write addr 6, char 0x00; cursor moves to (0,1).
- Reset asserted during WRITE with wr_ready=0 -> after the edge wr_valid=0, cursor (0,0), dir_down=0; no write is accepted afterward.
